// File: rtl/pipe_pkg.sv
// Shared pipeline types: ALU command encoding and datapath widths.
package pipe_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RADDR_DEF = 5;

  typedef enum logic [3:0] {
    EXE_ADD          = 4'd0,
    EXE_SUB          = 4'd1,
    EXE_AND          = 4'd2,
    EXE_OR           = 4'd3,
    EXE_NOR          = 4'd4,
    EXE_XOR          = 4'd5,
    EXE_SLA          = 4'd6,
    EXE_SLL          = 4'd7,
    EXE_SRA          = 4'd8,
    EXE_SRL          = 4'd9,
    EXE_NO_OPERATION = 4'd10
  } execmd_t;

endpackage

// File: rtl/exe_stage_if.sv
// Execute-stage bundle: ID/EX inputs, forwarding taps, EX/MEM outputs.
interface exe_stage_if
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF
) ();

  logic             stall;
  logic             flush;
  execmd_t          exe_cmd;
  logic [XLEN-1:0]  val1;
  logic [XLEN-1:0]  val2;
  logic             val2_is_reg;
  logic [XLEN-1:0]  st_value_in;
  logic [RADDR-1:0] src1;
  logic [RADDR-1:0] src2;
  logic [RADDR-1:0] dest_in;
  logic [XLEN-1:0]  pc_in;
  logic             mem_r_en_in;
  logic             mem_w_en_in;
  logic             wb_en_in;
  logic             br_taken_in;
  logic [RADDR-1:0] mem_fwd_dest;
  logic             mem_fwd_wb_en;
  logic [XLEN-1:0]  mem_fwd_val;
  logic [RADDR-1:0] wb_fwd_dest;
  logic             wb_fwd_wb_en;
  logic [XLEN-1:0]  wb_fwd_val;
  logic [XLEN-1:0]  alu_res;
  logic [XLEN-1:0]  st_value;
  logic [RADDR-1:0] dest;
  logic [XLEN-1:0]  pc;
  logic             mem_r_en;
  logic             mem_w_en;
  logic             wb_en;
  logic             br_taken;

  modport master (
    output stall, flush, exe_cmd,
    output val1, val2, val2_is_reg,
    output st_value_in, src1, src2,
    output dest_in, pc_in,
    output mem_r_en_in, mem_w_en_in,
    output wb_en_in, br_taken_in,
    output mem_fwd_dest, mem_fwd_wb_en,
    output mem_fwd_val,
    output wb_fwd_dest, wb_fwd_wb_en,
    output wb_fwd_val,
    input  alu_res, st_value, dest, pc,
    input  mem_r_en, mem_w_en,
    input  wb_en, br_taken
  );

  modport slave (
    input  stall, flush, exe_cmd,
    input  val1, val2, val2_is_reg,
    input  st_value_in, src1, src2,
    input  dest_in, pc_in,
    input  mem_r_en_in, mem_w_en_in,
    input  wb_en_in, br_taken_in,
    input  mem_fwd_dest, mem_fwd_wb_en,
    input  mem_fwd_val,
    input  wb_fwd_dest, wb_fwd_wb_en,
    input  wb_fwd_val,
    output alu_res, st_value, dest, pc,
    output mem_r_en, mem_w_en,
    output wb_en, br_taken
  );

endinterface

// File: rtl/exe_alu.sv
// Combinational ALU: wrap-around arithmetic, no flags.
module exe_alu
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  execmd_t         i_cmd,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic [XLEN-1:0] o_res
);

  logic [4:0] w_sh;
  assign w_sh = i_op2[4:0];

  always_comb begin
    o_res = '0;
    unique case (i_cmd)
      EXE_ADD: o_res = i_op1 + i_op2;
      EXE_SUB: o_res = i_op1 - i_op2;
      EXE_AND: o_res = i_op1 & i_op2;
      EXE_OR:  o_res = i_op1 | i_op2;
      EXE_NOR: o_res = ~(i_op1 | i_op2);
      EXE_XOR: o_res = i_op1 ^ i_op2;
      EXE_SLA: o_res = i_op1 << w_sh;
      EXE_SLL: o_res = i_op1 << w_sh;
      EXE_SRA: o_res = $signed(i_op1) >>> w_sh;
      EXE_SRL: o_res = i_op1 >> w_sh;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, EX/MEM pipeline register.
module exe_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input logic       clk,
  input logic       rstn,
  exe_stage_if.slave bus
);

  // MEM beats WB; x0 is hardwired and never forwarded
  function automatic logic [XLEN-1:0] fwd(
    input logic [RADDR-1:0] idx,
    input logic [XLEN-1:0]  v,
    input logic [RADDR-1:0] md,
    input logic             me,
    input logic [XLEN-1:0]  mv,
    input logic [RADDR-1:0] wd,
    input logic             we,
    input logic [XLEN-1:0]  wv
  );
    logic [XLEN-1:0] r;
    r = v;
    if (idx != '0) begin
      if (me && md == idx)      r = mv;
      else if (we && wd == idx) r = wv;
    end
    return r;
  endfunction

  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_st;
  logic [XLEN-1:0] w_res;

  assign w_op1 = fwd(bus.src1, bus.val1,
    bus.mem_fwd_dest, bus.mem_fwd_wb_en,
    bus.mem_fwd_val, bus.wb_fwd_dest,
    bus.wb_fwd_wb_en, bus.wb_fwd_val);
  assign w_rs2 = fwd(bus.src2, bus.val2,
    bus.mem_fwd_dest, bus.mem_fwd_wb_en,
    bus.mem_fwd_val, bus.wb_fwd_dest,
    bus.wb_fwd_wb_en, bus.wb_fwd_val);
  assign w_st = fwd(bus.src2, bus.st_value_in,
    bus.mem_fwd_dest, bus.mem_fwd_wb_en,
    bus.mem_fwd_val, bus.wb_fwd_dest,
    bus.wb_fwd_wb_en, bus.wb_fwd_val);
  assign w_op2 = bus.val2_is_reg ? w_rs2 : bus.val2;

  exe_alu #(.XLEN(XLEN)) u_alu (
    .i_cmd (bus.exe_cmd),
    .i_op1 (w_op1),
    .i_op2 (w_op2),
    .o_res (w_res)
  );

  logic [XLEN-1:0]  r_alu_res;
  logic [XLEN-1:0]  r_st_value;
  logic [RADDR-1:0] r_dest;
  logic [XLEN-1:0]  r_pc;
  logic [3:0]       r_ctl;

  always_ff @(posedge clk) begin
    if (!rstn || bus.flush) begin
      r_alu_res  <= '0;
      r_st_value <= '0;
      r_dest     <= '0;
      r_pc       <= '0;
      r_ctl      <= '0;
    end else if (!bus.stall) begin
      r_alu_res  <= w_res;
      r_st_value <= w_st;
      r_dest     <= bus.dest_in;
      r_pc       <= bus.pc_in;
      r_ctl      <= {bus.mem_r_en_in,
                     bus.mem_w_en_in,
                     bus.wb_en_in,
                     bus.br_taken_in};
    end
  end

  assign bus.alu_res  = r_alu_res;
  assign bus.st_value = r_st_value;
  assign bus.dest     = r_dest;
  assign bus.pc       = r_pc;
  assign bus.mem_r_en = r_ctl[3];
  assign bus.mem_w_en = r_ctl[2];
  assign bus.wb_en    = r_ctl[1];
  assign bus.br_taken = r_ctl[0];

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: vector table plus stall/flush/reset sequences.
module tb_exe_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  exe_stage_if #(.XLEN(32), .RADDR(5)) bus ();

  exe_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    execmd_t     cmd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        v2r;
    logic [31:0] st;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic [31:0] pc;
    logic [3:0]  ctl;
    logic [4:0]  md;
    logic        me;
    logic [31:0] mv;
    logic [4:0]  wd;
    logic        we;
    logic [31:0] wv;
    logic [31:0] ea;
    logic [31:0] es;
  } vec_t;

  vec_t tv[17];

  task automatic apply(input vec_t v);
    bus.exe_cmd       = v.cmd;
    bus.val1          = v.v1;
    bus.val2          = v.v2;
    bus.val2_is_reg   = v.v2r;
    bus.st_value_in   = v.st;
    bus.src1          = v.s1;
    bus.src2          = v.s2;
    bus.dest_in       = v.d;
    bus.pc_in         = v.pc;
    bus.mem_r_en_in   = v.ctl[3];
    bus.mem_w_en_in   = v.ctl[2];
    bus.wb_en_in      = v.ctl[1];
    bus.br_taken_in   = v.ctl[0];
    bus.mem_fwd_dest  = v.md;
    bus.mem_fwd_wb_en = v.me;
    bus.mem_fwd_val   = v.mv;
    bus.wb_fwd_dest   = v.wd;
    bus.wb_fwd_wb_en  = v.we;
    bus.wb_fwd_val    = v.wv;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] ea,
                         input logic [31:0] es,
                         input logic [4:0]  ed,
                         input logic [31:0] ep,
                         input logic [3:0]  ec);
    logic [3:0] c;
    c = {bus.mem_r_en, bus.mem_w_en,
         bus.wb_en, bus.br_taken};
    chk({tag, ".alu_res"},  bus.alu_res,  ea);
    chk({tag, ".st_value"}, bus.st_value, es);
    chk({tag, ".dest"}, {27'd0, bus.dest}, {27'd0, ed});
    chk({tag, ".pc"},       bus.pc,       ep);
    chk({tag, ".ctl"}, {28'd0, c}, {28'd0, ec});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = '{EXE_ADD, 5, 7, 1, 0, 1, 2, 3, 32'h10,
               4'b0010, 0, 0, 0, 0, 0, 0, 12, 0};
    tv[1]  = '{EXE_ADD, 0, 1, 0, 0, 3, 0, 5, 32'h14,
               4'b0010, 3, 1, 100, 3, 1, 200, 101, 0};
    tv[2]  = '{EXE_OR, 4, 0, 0, 0, 0, 0, 6, 32'h18,
               4'b0010, 0, 1, 9, 0, 1, 9, 4, 0};
    tv[3]  = '{EXE_ADD, 10, 5, 0, 32'h11, 1, 6, 7,
               32'h1C, 4'b0010, 0, 0, 0, 6, 1, 50, 15, 50};
    tv[4]  = '{EXE_SRA, 32'h8000_0000, 32'h24, 0, 0,
               1, 2, 8, 32'h20, 4'b0010, 0, 0, 0, 0, 0, 0,
               32'hF800_0000, 0};
    tv[5]  = '{EXE_SUB, 0, 1, 0, 0, 1, 2, 9, 32'h24,
               4'b0010, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0};
    tv[6]  = '{EXE_NOR, 0, 0, 0, 0, 1, 2, 10, 32'h28,
               4'b0010, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0};
    tv[7]  = '{EXE_ADD, 32'h100, 4, 0, 0, 1, 7, 0,
               32'h2C, 4'b0100, 0, 0, 0, 7, 1,
               32'hDEAD_BEEF, 32'h104, 32'hDEAD_BEEF};
    tv[8]  = '{EXE_SUB, 50, 999, 1, 3, 1, 4, 9, 32'h30,
               4'b0010, 0, 0, 0, 4, 1, 8, 42, 8};
    tv[9]  = '{EXE_SLL, 1, 32'hFFFF_FFFF, 0, 0, 1, 2, 11,
               32'h34, 4'b0010, 0, 0, 0, 0, 0, 0,
               32'h8000_0000, 0};
    tv[10] = '{EXE_SRL, 32'h8000_0000, 32'h3F, 0, 0,
               1, 2, 12, 32'h38, 4'b1010, 0, 0, 0, 0, 0, 0,
               1, 0};
    tv[11] = '{EXE_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 0,
               0, 1, 2, 13, 32'h3C, 4'b0010,
               0, 0, 0, 0, 0, 0, 32'h0FF0_0FF0, 0};
    tv[12] = '{EXE_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0,
               0, 1, 2, 14, 32'h40, 4'b0010,
               0, 0, 0, 0, 0, 0, 32'hF000_F000, 0};
    tv[13] = '{EXE_NO_OPERATION, 7, 7, 0, 0, 1, 2, 15,
               32'h44, 4'b1001, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[14] = '{EXE_ADD, 0, 1, 0, 0, 3, 0, 16, 32'h48,
               4'b0010, 3, 0, 100, 3, 1, 200, 201, 0};
    tv[15] = '{EXE_SLA, 3, 2, 0, 32'h77, 1, 5, 17,
               32'h4C, 4'b0110, 5, 1, 32'h55, 5, 1, 32'h66,
               12, 32'h55};
    tv[16] = '{EXE_OR, 32'h100, 0, 1, 0, 0, 5, 18,
               32'h50, 4'b0010, 5, 1, 32'h0F, 0, 0, 0,
               32'h10F, 32'h0F};

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rstn = 1'b0;
    apply(tv[0]);
    @(negedge clk);
    step();
    chk_all("reset", 0, 0, 0, 0, 0);
    step();
    chk_all("reset2", 0, 0, 0, 0, 0);
    rstn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(tv[i]);
      step();
      chk_all($sformatf("vec%0d", i), tv[i].ea,
              tv[i].es, tv[i].d, tv[i].pc, tv[i].ctl);
    end

    // stall holds for three cycles with changing inputs
    apply(tv[0]);
    step();
    chk_all("preload", 12, 0, 3, 32'h10, 4'b0010);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(tv[4 + k]);
      step();
      chk_all($sformatf("stall%0d", k), 12, 0, 3,
              32'h10, 4'b0010);
    end
    bus.flush = 1'b1;
    step();
    chk_all("flush_stall", 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    apply(tv[7]);
    step();
    chk_all("store", 32'h104, 32'hDEAD_BEEF, 0,
            32'h2C, 4'b0100);
    bus.flush = 1'b1;
    step();
    chk_all("flush", 0, 0, 0, 0, 0);
    bus.flush = 1'b0;

    apply(tv[8]);
    step();
    chk_all("reload", 42, 8, 9, 32'h30, 4'b0010);
    bus.stall = 1'b1;
    rstn = 1'b0;
    step();
    chk_all("rst_stall", 0, 0, 0, 0, 0);
    rstn = 1'b1;
    bus.stall = 1'b0;
    step();
    chk_all("after_rst", 42, 8, 9, 32'h30, 4'b0010);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage RV32-style pipeline and the consumer of the ID/EX pipeline register outputs. It does three things:
- Resolves operand forwarding from the MEM and WB stages.
- Evaluates the ALU command.
- Registers the result together with the memory/writeback controls into the EX/MEM pipeline register, with stall-hold and flush-bubble support.

## Interface
Parameters:
- XLEN, 32, datapath width
- RADDR, 5, register-index width

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- stall  in  1  hold EX/MEM contents
- flush  in  1  insert bubble into EX/MEM
- exe_cmd  in  execmd_t  ALU command from ID/EX
- val1  in  XLEN  operand 1 (rs1 value)
- val2  in  XLEN  operand 2 (rs2 value or immediate)
- val2_is_reg  in  1  val2 came from rs2 (forwarding enabled on val2)
- st_value_in  in  XLEN  store data (rs2 value)
- src1, src2  in  RADDR  source register indices
- dest_in  in  RADDR  destination index
- pc_in  in  XLEN  instruction PC
- mem_r_en_in, mem_w_en_in, wb_en_in, br_taken_in  in  1 each  controls from ID/EX
- mem_fwd_dest  in  RADDR  destination index currently in MEM
- mem_fwd_wb_en  in  1  MEM instruction writes back
- mem_fwd_val  in  XLEN  MEM-stage ALU result
- wb_fwd_dest  in  RADDR  destination index currently in WB
- wb_fwd_wb_en  in  1  WB instruction writes back
- wb_fwd_val  in  XLEN  WB-stage writeback value
- alu_res  out  XLEN  registered ALU result
- st_value  out  XLEN  registered forwarded store data
- dest  out  RADDR  registered destination
- pc  out  XLEN  registered PC
- mem_r_en, mem_w_en, wb_en, br_taken  out  1 each  registered controls

## Operation
Forwarding (combinational), applied to op1 (from val1, index src1) and to store data (from st_value_in, index src2):
- Source index 0 is never forwarded.
- If mem_fwd_wb_en and mem_fwd_dest==index, use mem_fwd_val.
- Else if wb_fwd_wb_en and wb_fwd_dest==index, use wb_fwd_val.
- Else use the ID/EX value.
- MEM has priority over WB.
- op2 follows the same rules (index src2) only when val2_is_reg=1. Otherwise op2=val2 unmodified.

ALU, XLEN-bit results with wrap-around and no flags:
- ADD: op1+op2
- SUB: op1−op2
- AND, OR, XOR: bitwise
- NOR: ~(op1|op2)
- SLA, SLL: op1<<op2[4:0]
- SRA: arithmetic right shift by op2[4:0]
- SRL: logical right shift by op2[4:0]
- NO_OPERATION: result 0

Shift amount uses op2[4:0] only; upper bits are ignored.

EX/MEM register update priority: rstn low > flush > stall > load.
- Reset: every output is 0.
- Flush: every output is 0; this is a bubble.
- Stall: all outputs hold their values.
- Load: capture the ALU result, forwarded store data, dest_in, pc_in and the four controls.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Forwarding values are sampled in the same cycle as the consuming instruction; there is no added bubble. The load-use hazard is the hazard unit's job; this block assumes it is already stalled upstream.
- When flush and stall are asserted together, flush wins.
- Reset asserted mid-stall clears the outputs at the next edge.
- Stall does not gate forwarding. Forwarded values are simply not captured while stalled.
- There are no internal state or counters beyond the EX/MEM register.

## Structure
- Shared package `pipe_pkg` holds:
  - execmd_t: EXE_ADD=0, EXE_SUB, EXE_AND, EXE_OR, EXE_NOR, EXE_XOR, EXE_SLA, EXE_SLL, EXE_SRA, EXE_SRL, EXE_NO_OPERATION=10
  - XLEN and RADDR defaults
- The ID/EX register and the hazard unit import the same package.
- One sub-module, `exe_alu`, is purely combinational (cmd, op1, op2 → result).
- Forwarding muxes and the EX/MEM register live in `exe_stage`.

## Test plan
- Reset, then ADD with val1=5, val2=7 and no forwarding hits → alu_res=12 one cycle later. All outputs are 0 during reset.
- src1=3, mem_fwd_dest=3, mem_fwd_wb_en=1, mem_fwd_val=100, wb_fwd_dest=3, wb_fwd_val=200, ADD with val2=1 → alu_res=101 (MEM priority).
- src1=0 while mem_fwd_dest=0 with wb_en=1 and mem_fwd_val=9, val1=4, OR with val2=0 → alu_res=4 (no forwarding from x0). Separately, val2_is_reg=0 with src2 matching WB → op2 is the immediate.
- SRA with val1=0x8000_0000, val2=0x0000_0024 → alu_res=0xF800_0000 (shift by 4). SUB with 0−1 → 0xFFFF_FFFF. NOR with 0,0 → 0xFFFF_FFFF.
- Load an instruction with wb_en=1, then assert stall for 3 cycles with changing inputs → outputs unchanged. Assert flush+stall together → all outputs 0 next cycle.
- Store with mem_w_en_in=1, src2=7, wb_fwd_dest=7, wb_fwd_val=0xDEAD_BEEF, st_value_in=0 → st_value=0xDEAD_BEEF, mem_w_en=1.
